// File: rtl/dl_pow_pkg_60m.sv
// Shared definitions for the downlink power coefficient config controller:
// FSM encodings, address map and the unity default coefficient.
package dl_pow_pkg_60m;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int          MAX_ANT     = 8;
    localparam logic [3:0]  BYPASS_ADDR = 4'd8;
    localparam logic [31:0] DEF_POW     = 32'h7FFF_0000;

    // The unused encoding 3 behaves exactly like IDLE.
    function automatic state_e decode_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return ST_ARMED;
            2'd2:    return ST_COMMIT;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dl_pow_bank_60m.sv
// XNUM-entry coefficient register bank: single-word write port, whole-bank
// parallel load, and all entries visible in parallel on rd_data.
module dl_pow_bank_60m #(
    parameter int          XNUM    = 8,
    parameter logic [31:0] DEF_POW = 32'h7FFF_0000
) (
    input  logic                 clk,
    input  logic                 asy_rst,
    input  logic                 wr_en,
    input  logic [2:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 load_en,
    input  logic [XNUM*32-1:0]   load_data,
    output logic [XNUM*32-1:0]   rd_data
);

    logic [XNUM*32-1:0] mem_q;
    logic [XNUM*32-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (load_en) begin
            mem_d = load_data;
        end else if (wr_en) begin
            for (int i = 0; i < XNUM; i++) begin
                if (int'(wr_addr) == i) begin
                    mem_d[i*32 +: 32] = wr_data;
                end
            end
        end
    end

    // NOTE: this bank is a handful of flops, not a RAM, so it is reset; the
    // datapath must see unity gain straight out of reset.
    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            mem_q <= {XNUM{DEF_POW}};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: rtl/dl_pow_cfg_ctrl_60m.sv
// Double-buffered power coefficient config: the cfg port fills a shadow bank,
// which is copied to the active bank on the first frame header after a commit.
module dl_pow_cfg_ctrl_60m #(
    parameter int          XNUM    = 8,
    parameter logic [31:0] DEF_POW = dl_pow_pkg_60m::DEF_POW,
    parameter int          TMO_CYC = 61440
) (
    input  logic        clk,
    input  logic        asy_rst,
    input  logic        i_cfg_wr,
    input  logic [3:0]  i_cfg_addr,
    input  logic [31:0] i_cfg_wdata,
    output logic        o_cfg_ready,
    input  logic        i_commit_req,
    output logic        o_commit_ack,
    input  logic        i_fram_hd,
    output logic [31:0] o_ant0_pow,
    output logic [31:0] o_ant1_pow,
    output logic [31:0] o_ant2_pow,
    output logic [31:0] o_ant3_pow,
    output logic [31:0] o_ant4_pow,
    output logic [31:0] o_ant5_pow,
    output logic [31:0] o_ant6_pow,
    output logic [31:0] o_ant7_pow,
    output logic        o_power_bypass,
    output logic        o_cfg_err,
    output logic [1:0]  o_state
);
    import dl_pow_pkg_60m::*;

    localparam int                CNT_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TMO_CYC - 1);

    logic [1:0]          state_q, state_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                shd_byp_q, shd_byp_d;
    logic                act_byp_q, act_byp_d;
    logic                tmo_hit;

    state_e              cur_st;
    logic                is_idle;
    logic                addr_is_ant;
    logic                addr_is_byp;
    logic                shd_wr;
    logic                err_set;
    logic                err_clr;
    logic [XNUM*32-1:0]  shd_flat;
    logic [XNUM*32-1:0]  act_flat;
    logic [31:0]         ant_pow [MAX_ANT];

    assign cur_st      = decode_state(state_q);
    assign is_idle     = (cur_st == ST_IDLE);
    assign addr_is_ant = (int'(i_cfg_addr) < XNUM);
    assign addr_is_byp = (i_cfg_addr == BYPASS_ADDR);
    assign shd_wr      = i_cfg_wr && is_idle && addr_is_ant;

    // NOTE: every variable gets a default at the top of the block, so no
    // path through the case can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        cnt_d     = cnt_q;
        shd_byp_d = shd_byp_q;
        act_byp_d = act_byp_q;
        tmo_hit   = 1'b0;
        case (cur_st)
            ST_IDLE: begin
                if (i_cfg_wr && addr_is_byp) shd_byp_d = i_cfg_wdata[0];
                if (i_commit_req) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end
            ST_ARMED: begin
                // A header in the final cycle still commits.
                if (i_fram_hd) begin
                    state_d = ST_COMMIT;
                    ack_d   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    tmo_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d   = ST_IDLE;
                act_byp_d = shd_byp_q;
            end
            default: state_d = ST_IDLE;
        endcase

        err_set = (i_cfg_wr && (!is_idle || !(addr_is_ant || addr_is_byp)))
                || (i_commit_req && !is_idle) || tmo_hit;
        err_clr = i_cfg_wr && is_idle && addr_is_byp && i_cfg_wdata[31];
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values computed before this edge.
    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            shd_byp_q <= 1'b0;
            act_byp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            shd_byp_q <= shd_byp_d;
            act_byp_q <= act_byp_d;
        end
    end

    dl_pow_bank_60m #(.XNUM(XNUM), .DEF_POW(DEF_POW)) u_shadow (
        .clk       (clk),
        .asy_rst   (asy_rst),
        .wr_en     (shd_wr),
        .wr_addr   (i_cfg_addr[2:0]),
        .wr_data   (i_cfg_wdata),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_data   (shd_flat)
    );

    dl_pow_bank_60m #(.XNUM(XNUM), .DEF_POW(DEF_POW)) u_active (
        .clk       (clk),
        .asy_rst   (asy_rst),
        .wr_en     (1'b0),
        .wr_addr   (3'd0),
        .wr_data   (32'd0),
        .load_en   (cur_st == ST_COMMIT),
        .load_data (shd_flat),
        .rd_data   (act_flat)
    );

    for (genvar g = 0; g < MAX_ANT; g++) begin : g_ant
        if (g < XNUM) begin : g_live
            assign ant_pow[g] = act_flat[g*32 +: 32];
        end else begin : g_fixed
            assign ant_pow[g] = DEF_POW;
        end
    end

    assign o_ant0_pow     = ant_pow[0];
    assign o_ant1_pow     = ant_pow[1];
    assign o_ant2_pow     = ant_pow[2];
    assign o_ant3_pow     = ant_pow[3];
    assign o_ant4_pow     = ant_pow[4];
    assign o_ant5_pow     = ant_pow[5];
    assign o_ant6_pow     = ant_pow[6];
    assign o_ant7_pow     = ant_pow[7];
    assign o_power_bypass = act_byp_q;
    assign o_cfg_ready    = is_idle;
    assign o_commit_ack   = ack_q;
    assign o_cfg_err      = err_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_dl_pow_cfg_ctrl_60m.sv
// Scoreboard bench: expected active banks are queued when a committing frame
// header is driven and compared when the DUT acknowledges the commit.
module tb_dl_pow_cfg_ctrl_60m;

    localparam int          XNUM = 8;
    localparam int          TMO  = 256;
    localparam logic [31:0] DEF  = 32'h7FFF_0000;

    logic        clk = 1'b0;
    logic        asy_rst;
    logic        i_cfg_wr;
    logic [3:0]  i_cfg_addr;
    logic [31:0] i_cfg_wdata;
    logic        i_commit_req;
    logic        i_fram_hd;
    logic        o_cfg_ready, o_commit_ack, o_power_bypass, o_cfg_err;
    logic [1:0]  o_state;
    logic [31:0] o_ant0_pow, o_ant1_pow, o_ant2_pow, o_ant3_pow;
    logic [31:0] o_ant4_pow, o_ant5_pow, o_ant6_pow, o_ant7_pow;
    logic [31:0] ant_w [8];

    always #5 clk = ~clk;

    dl_pow_cfg_ctrl_60m #(.XNUM(XNUM), .DEF_POW(DEF), .TMO_CYC(TMO)) dut (
        .clk            (clk),
        .asy_rst        (asy_rst),
        .i_cfg_wr       (i_cfg_wr),
        .i_cfg_addr     (i_cfg_addr),
        .i_cfg_wdata    (i_cfg_wdata),
        .o_cfg_ready    (o_cfg_ready),
        .i_commit_req   (i_commit_req),
        .o_commit_ack   (o_commit_ack),
        .i_fram_hd      (i_fram_hd),
        .o_ant0_pow     (o_ant0_pow),
        .o_ant1_pow     (o_ant1_pow),
        .o_ant2_pow     (o_ant2_pow),
        .o_ant3_pow     (o_ant3_pow),
        .o_ant4_pow     (o_ant4_pow),
        .o_ant5_pow     (o_ant5_pow),
        .o_ant6_pow     (o_ant6_pow),
        .o_ant7_pow     (o_ant7_pow),
        .o_power_bypass (o_power_bypass),
        .o_cfg_err      (o_cfg_err),
        .o_state        (o_state)
    );

    assign ant_w[0] = o_ant0_pow;
    assign ant_w[1] = o_ant1_pow;
    assign ant_w[2] = o_ant2_pow;
    assign ant_w[3] = o_ant3_pow;
    assign ant_w[4] = o_ant4_pow;
    assign ant_w[5] = o_ant5_pow;
    assign ant_w[6] = o_ant6_pow;
    assign ant_w[7] = o_ant7_pow;

    typedef struct packed {
        logic             byp;
        logic [7:0][31:0] pow;
    } bank_t;

    bank_t shd_m;
    bank_t act_m;
    bank_t mon_exp;
    bank_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_ack    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bank_t def_bank();
        bank_t b;
        for (int i = 0; i < 8; i++) b.pow[i] = DEF;
        b.byp = 1'b0;
        return b;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bank(input string tag, input bank_t e);
        for (int i = 0; i < 8; i++) check($sformatf("%s_ant%0d", tag, i), ant_w[i], e.pow[i]);
        check({tag, "_byp"}, 32'(o_power_bypass), 32'(e.byp));
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input bit accept);
        i_cfg_wr    = 1'b1;
        i_cfg_addr  = a;
        i_cfg_wdata = d;
        if (accept && int'(a) < XNUM) shd_m.pow[a] = d;
        else if (accept && a == 4'd8) shd_m.byp = d[0];
        tick();
        i_cfg_wr = 1'b0;
    endtask

    task automatic commit_pulse();
        i_commit_req = 1'b1;
        tick();
        i_commit_req = 1'b0;
    endtask

    task automatic frame_commit(input string tag);
        i_fram_hd = 1'b1;
        sb_q.push_back(shd_m);
        tick();
        i_fram_hd = 1'b0;
        check({tag, "_ack"}, 32'(o_commit_ack), 32'd1);
        check({tag, "_st_commit"}, 32'(o_state), 32'd2);
        tick(3);
        check({tag, "_st_idle"}, 32'(o_state), 32'd0);
    endtask

    // Ack monitor: old bank during the ack cycle, expected bank one cycle later.
    always @(negedge clk) begin
        if (!asy_rst && o_commit_ack) begin
            n_ack++;
            check_bank("pre_commit", act_m);
            @(negedge clk);
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                check_bank("post_commit", mon_exp);
                act_m = mon_exp;
            end
        end
    end

    initial begin
        asy_rst      = 1'b1;
        i_cfg_wr     = 1'b0;
        i_cfg_addr   = '0;
        i_cfg_wdata  = '0;
        i_commit_req = 1'b0;
        i_fram_hd    = 1'b0;
        shd_m        = def_bank();
        act_m        = def_bank();
        tick(3);
        asy_rst = 1'b0;
        tick();

        // Reset state
        check_bank("rst", act_m);
        check("rst_ready", 32'(o_cfg_ready), 32'd1);
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_err", 32'(o_cfg_err), 32'd0);
        check("rst_ack", 32'(o_commit_ack), 32'd0);

        // Basic commit, header 10 cycles after the request
        cfg_write(4'd3, 32'h4000_0000, 1'b1);
        cfg_write(4'd8, 32'h0000_0001, 1'b1);
        commit_pulse();
        check("armed_state", 32'(o_state), 32'd1);
        check("armed_ready", 32'(o_cfg_ready), 32'd0);
        tick(9);
        frame_commit("basic");

        // Write while ARMED is dropped and flags an error
        commit_pulse();
        cfg_write(4'd0, 32'h1234_5678, 1'b0);
        check("armed_wr_err", 32'(o_cfg_err), 32'd1);
        tick(20);
        frame_commit("armed_wr");
        cfg_write(4'd8, 32'h8000_0001, 1'b1);
        check("err_clr1", 32'(o_cfg_err), 32'd0);

        // Timeout: ARMED for exactly TMO cycles, then IDLE with no commit
        cfg_write(4'd5, 32'h1111_2222, 1'b1);
        commit_pulse();
        tick(TMO - 1);
        check("tmo_last_armed", 32'(o_state), 32'd1);
        tick();
        check("tmo_idle", 32'(o_state), 32'd0);
        check("tmo_err", 32'(o_cfg_err), 32'd1);
        check_bank("tmo_hold", act_m);
        cfg_write(4'd8, 32'h8000_0000, 1'b1);
        check("err_clr2", 32'(o_cfg_err), 32'd0);

        // Header in the final ARMED cycle wins over the timeout
        commit_pulse();
        tick(TMO - 1);
        frame_commit("tmo_edge");
        check("tmo_edge_err", 32'(o_cfg_err), 32'd0);

        // Illegal addresses set the error and store nothing
        cfg_write(4'd13, 32'hDEAD_BEEF, 1'b0);
        check("ill_err", 32'(o_cfg_err), 32'd1);
        cfg_write(4'd15, 32'hCAFE_F00D, 1'b0);
        cfg_write(4'd8, 32'h8000_0000, 1'b1);
        check("err_clr3", 32'(o_cfg_err), 32'd0);

        // Header coincident with the request (and a same-cycle write) is ignored
        i_cfg_wr     = 1'b1;
        i_cfg_addr   = 4'd1;
        i_cfg_wdata  = 32'hAAAA_5555;
        i_commit_req = 1'b1;
        i_fram_hd    = 1'b1;
        shd_m.pow[1] = 32'hAAAA_5555;
        tick();
        i_cfg_wr     = 1'b0;
        i_commit_req = 1'b0;
        i_fram_hd    = 1'b0;
        check("coinc_state", 32'(o_state), 32'd1);
        check("coinc_ack", 32'(o_commit_ack), 32'd0);
        commit_pulse();
        check("req_armed_err", 32'(o_cfg_err), 32'd1);
        check("req_armed_state", 32'(o_state), 32'd1);
        tick(98);
        frame_commit("coinc");
        cfg_write(4'd8, 32'h8000_0000, 1'b1);
        check("err_clr4", 32'(o_cfg_err), 32'd0);

        // Reset while ARMED with a modified shadow
        cfg_write(4'd4, 32'h5555_AAAA, 1'b1);
        commit_pulse();
        tick(5);
        asy_rst = 1'b1;
        tick(2);
        asy_rst = 1'b0;
        shd_m   = def_bank();
        act_m   = def_bank();
        check_bank("rst2", act_m);
        check("rst2_state", 32'(o_state), 32'd0);
        check("rst2_ack", 32'(o_commit_ack), 32'd0);
        check("rst2_err", 32'(o_cfg_err), 32'd0);
        check("rst2_ready", 32'(o_cfg_ready), 32'd1);
        commit_pulse();
        tick(3);
        frame_commit("post_rst");
        tick(3);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("ack_count", 32'(n_ack), 32'd5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_pow_cfg_ctrl_60m.md
DL_POW_CFG_CTRL_60M -- requirements
Module: dl_pow_cfg_ctrl_60m

Interface
REQ-001 Parameter: XNUM, 8, number of antenna power coefficients (1..8).
REQ-002 Parameter: DEF_POW, 32'h7FFF_0000, reset/default coefficient (real Q1.15 unity in [31:16], imag 0 in [15:0]).
REQ-003 Parameter: TMO_CYC, 61440, maximum cycles ARMED waits for a frame header.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 asy_rst  in  1  asynchronous, active-high reset.
REQ-006 i_cfg_wr  in  1  config write strobe, one write per cycle.
REQ-007 i_cfg_addr  in  4  0..XNUM-1 = antenna coefficient, 8 = bypass register, others illegal.
REQ-008 i_cfg_wdata  in  32  write data; bypass uses bit 0 only.
REQ-009 o_cfg_ready  out  1  writes accepted this cycle.
REQ-010 i_commit_req  in  1  single-cycle pulse requesting shadow-to-active transfer.
REQ-011 o_commit_ack  out  1  single-cycle pulse, cycle the active bank updates.
REQ-012 i_fram_hd  in  1  frame header pulse, same timing as datapath frame header.
REQ-013 o_ant0_pow..o_ant7_pow  out  32 each  active coefficients to power datapath.
REQ-014 o_power_bypass  out  1  active bypass select to power datapath.
REQ-015 o_cfg_err  out  1  sticky error flag, cleared by write of 1 to bit 31 at addr 8.
REQ-016 o_state  out  2  current FSM state encoding for debug.

Function
REQ-017 Two banks: shadow (written by cfg port) and active (drives outputs); outputs change only on commit.
REQ-018 FSM states IDLE=0, ARMED=1, COMMIT=2; encoding 3 unused, decodes to IDLE.
REQ-019 IDLE: o_cfg_ready=1; i_cfg_wr with legal addr updates shadow entry next cycle.
REQ-020 IDLE + i_commit_req -> ARMED; a write in the same cycle is accepted first and included in the commit.
REQ-021 ARMED: o_cfg_ready=0; any i_cfg_wr is dropped and sets o_cfg_err.
REQ-022 ARMED + i_fram_hd -> COMMIT; i_fram_hd coincident with the IDLE->ARMED transition cycle is ignored (wait next header).
REQ-023 COMMIT (one cycle): active <= shadow, o_commit_ack=1, next state IDLE; outputs valid from the following cycle.
REQ-024 Latency: i_fram_hd in ARMED at cycle N -> o_commit_ack at N+1 -> new o_antX_pow/o_power_bypass at N+2.
REQ-025 ARMED timeout: cycle counter reaches TMO_CYC-1 without i_fram_hd -> IDLE, no commit, o_cfg_err set.
REQ-026 Timeout and i_fram_hd in same cycle: i_fram_hd wins, commit proceeds.
REQ-027 i_commit_req outside IDLE is ignored and sets o_cfg_err.
REQ-028 Illegal address (9..15, or XNUM..7 when XNUM<8) write sets o_cfg_err, no storage change.
REQ-029 Coefficient outputs with index >= XNUM are held at DEF_POW permanently.
REQ-030 Timeout counter width ceil(log2(TMO_CYC)), cleared on entry to ARMED, no wrap.
REQ-031 Error-clear write at addr 8 with bit 31 set clears o_cfg_err; a new error in the same cycle takes priority (flag stays 1).

Reset
REQ-032 asy_rst asserted: state IDLE, shadow and active coefficients = DEF_POW, bypass = 0, o_commit_ack=0, o_cfg_err=0, counter=0, o_cfg_ready=1 after release.
REQ-033 Reset mid-ARMED or mid-COMMIT aborts: no partial bank transfer visible after release.

Structure
REQ-034 Shared package dl_pow_pkg_60m holds FSM state encodings, address map constants (BYPASS_ADDR=8) and DEF_POW.
REQ-035 One sub-module dl_pow_bank_60m: XNUM-entry 32-bit register bank with write port and parallel read, instantiated twice (shadow, active).

Verification
REQ-036 Reset, no writes: all o_antX_pow=32'h7FFF_0000, o_power_bypass=0, o_cfg_ready=1, o_state=0.
REQ-037 Write addr 3=32'h4000_0000, addr 8=1, commit, i_fram_hd 10 cycles later -> ack at +1, o_ant3_pow=32'h4000_0000, bypass=1 at +2, others unchanged.
REQ-038 Write while ARMED (addr 0=32'h1234_5678) -> not stored, o_cfg_err=1; after commit o_ant0_pow unchanged.
REQ-039 Commit with no i_fram_hd for TMO_CYC cycles -> return to IDLE, no ack, outputs unchanged, o_cfg_err=1; write 32'h8000_0000 to addr 8 clears it.
REQ-040 i_fram_hd coincident with i_commit_req -> no commit; next i_fram_hd 100 cycles later commits.
REQ-041 asy_rst pulse while ARMED with shadow modified -> outputs and shadow back to DEF_POW, state IDLE, no ack.
